core_sequencer: RTL and testbench

Boot and run-control sequencer for the 8-bit core. Accepts a byte-serial command stream from a host link, writes instruction words into the writable program memory that feeds the core's INSTR input, and controls the core through its reset and a clock-enable. Provides run, halt, single-step and one PC breakpoint for bring-up and test.

---
 rtl/core_sequencer.sv | 162 ++++++++++++++++
 tb/tb_core_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Boot and run-control sequencer: decodes a byte-serial host command stream,
// loads program memory, and gates the core through its reset and clock enable.
module core_sequencer #(
  parameter int PC_LEN    = 7,
  parameter int INSTR_LEN = 13
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           RX_DATA,
  input  logic                 RX_VALID,
  output logic                 RX_READY,
  output logic                 PROM_WE,
  output logic [PC_LEN-1:0]    PROM_WADDR,
  output logic [INSTR_LEN-1:0] PROM_WDATA,
  input  logic [PC_LEN-1:0]    PC,
  output logic                 CORE_RSTN,
  output logic                 CORE_CE,
  output logic [1:0]           RUN_STATE,
  output logic                 ERR
);

  typedef enum logic [2:0] {
    C_IDLE, C_LD_CNT, C_LD_LO, C_LD_HI, C_WRITE, C_BRK_ADR
  } ctl_state_t;

  typedef enum logic [1:0] {
    R_INRESET = 2'b00,
    R_RUNNING = 2'b01,
    R_HALTED  = 2'b10
  } run_state_t;

  localparam logic [7:0] CMD_LOAD   = 8'h01;
  localparam logic [7:0] CMD_RUN    = 8'h02;
  localparam logic [7:0] CMD_HALT   = 8'h03;
  localparam logic [7:0] CMD_STEP   = 8'h04;
  localparam logic [7:0] CMD_RESET  = 8'h05;
  localparam logic [7:0] CMD_BRK    = 8'h06;
  localparam logic [7:0] CMD_BRKOFF = 8'h07;

  ctl_state_t          ctl_state;
  run_state_t          run_state;
  logic [8:0]          words_left;
  logic                bp_en;
  logic [PC_LEN-1:0]   bp_addr;
  logic                resume_skip;
  logic                step_pulse;
  logic                rx_fire;
  logic                cmd_fire;
  logic                bp_hit;

  assign rx_fire  = RX_VALID & RX_READY;
  assign cmd_fire = rx_fire && (ctl_state == C_IDLE);
  // The first cycle after a resume ignores the compare so the core can leave
  // the breakpoint address instead of re-halting on it.
  assign bp_hit   = bp_en && (PC == bp_addr) && !resume_skip;

  // NOTE: state is written with <= only so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctl_state  <= C_IDLE;
      RX_READY   <= 1'b0;
      PROM_WE    <= 1'b0;
      PROM_WADDR <= '0;
      PROM_WDATA <= '0;
      words_left <= '0;
      bp_en      <= 1'b0;
      bp_addr    <= '0;
      ERR        <= 1'b0;
    end else begin
      PROM_WE  <= 1'b0;
      RX_READY <= 1'b1;
      case (ctl_state)
        C_IDLE: begin
          if (rx_fire) begin
            case (RX_DATA)
              CMD_LOAD: begin
                ctl_state  <= C_LD_CNT;
                PROM_WADDR <= '0;
              end
              CMD_BRK:    ctl_state <= C_BRK_ADR;
              CMD_BRKOFF: bp_en     <= 1'b0;
              CMD_RUN, CMD_HALT, CMD_STEP, CMD_RESET: begin
              end
              default:    ERR <= 1'b1;
            endcase
          end
        end
        C_LD_CNT: begin
          if (rx_fire) begin
            words_left <= (RX_DATA == 8'd0) ? 9'd256 : {1'b0, RX_DATA};
            ctl_state  <= C_LD_LO;
          end
        end
        C_LD_LO: begin
          if (rx_fire) begin
            PROM_WDATA[7:0] <= RX_DATA;
            ctl_state       <= C_LD_HI;
          end
        end
        C_LD_HI: begin
          if (rx_fire) begin
            PROM_WDATA[INSTR_LEN-1:8] <= RX_DATA[INSTR_LEN-9:0];
            PROM_WE   <= 1'b1;
            RX_READY  <= 1'b0;
            ctl_state <= C_WRITE;
          end
        end
        C_WRITE: begin
          PROM_WADDR <= PROM_WADDR + PC_LEN'(1);
          words_left <= words_left - 9'd1;
          ctl_state  <= (words_left == 9'd1) ? C_IDLE : C_LD_LO;
        end
        C_BRK_ADR: begin
          if (rx_fire) begin
            bp_addr   <= RX_DATA[PC_LEN-1:0];
            bp_en     <= 1'b1;
            ctl_state <= C_IDLE;
          end
        end
        default: ctl_state <= C_IDLE;
      endcase
    end
  end

  // Run FSM: a breakpoint halt is the default; a later command assignment in
  // the same cycle takes precedence.
  always_ff @(posedge CLK) begin
    if (RST) begin
      run_state   <= R_INRESET;
      resume_skip <= 1'b0;
      step_pulse  <= 1'b0;
    end else begin
      resume_skip <= 1'b0;
      step_pulse  <= 1'b0;
      if (run_state == R_RUNNING && bp_hit)
        run_state <= R_HALTED;
      if (cmd_fire) begin
        case (RX_DATA)
          CMD_LOAD, CMD_RESET: run_state <= R_INRESET;
          CMD_RUN: begin
            if (run_state == R_INRESET)
              run_state <= R_RUNNING;
            else if (run_state == R_HALTED) begin
              run_state   <= R_RUNNING;
              resume_skip <= 1'b1;
            end
          end
          CMD_HALT: if (run_state == R_RUNNING) run_state <= R_HALTED;
          CMD_STEP: if (run_state == R_HALTED) step_pulse <= 1'b1;
          default: begin
          end
        endcase
      end
    end
  end

  assign CORE_RSTN = (run_state != R_INRESET);
  assign CORE_CE   = ((run_state == R_RUNNING) && !bp_hit) ||
                     ((run_state == R_HALTED) && step_pulse);
  assign RUN_STATE = run_state;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed command sequences with
// randomized payloads, a behavioural core PC model and a write scoreboard.
module tb_core_sequencer;

  localparam int PC_LEN    = 7;
  localparam int INSTR_LEN = 13;
  localparam int DEPTH     = 1 << PC_LEN;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [7:0]           RX_DATA;
  logic                 RX_VALID;
  logic                 RX_READY;
  logic                 PROM_WE;
  logic [PC_LEN-1:0]    PROM_WADDR;
  logic [INSTR_LEN-1:0] PROM_WDATA;
  logic [PC_LEN-1:0]    PC;
  logic                 CORE_RSTN;
  logic                 CORE_CE;
  logic [1:0]           RUN_STATE;
  logic                 ERR;

  int tests = 0;
  int fails = 0;

  logic [PC_LEN-1:0]    waddr_q[$];
  logic [INSTR_LEN-1:0] wdata_q[$];
  logic [15:0]          words[$];

  core_sequencer #(.PC_LEN(PC_LEN), .INSTR_LEN(INSTR_LEN)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .PROM_WE(PROM_WE), .PROM_WADDR(PROM_WADDR),
    .PROM_WDATA(PROM_WDATA), .PC(PC), .CORE_RSTN(CORE_RSTN),
    .CORE_CE(CORE_CE), .RUN_STATE(RUN_STATE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Every program-memory write lands in the scoreboard, sampled mid-cycle.
  always @(negedge CLK) begin
    if (PROM_WE === 1'b1) begin
      waddr_q.push_back(PROM_WADDR);
      wdata_q.push_back(PROM_WDATA);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; the core model resets its PC while held in reset and advances
  // only on cycles where the enable was high before the edge.
  task automatic tick();
    logic ce, rstn;
    ce   = CORE_CE;
    rstn = CORE_RSTN;
    @(posedge CLK);
    #1;
    if (rstn !== 1'b1)    PC = '0;
    else if (ce === 1'b1) PC = PC + 7'd1;
    #1;
  endtask

  // Returns in the cycle right after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    while (RX_READY !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (RX_READY !== 1'b1) check("rx_ready_timeout", 32'(RX_READY), 32'd1);
    else tick();
    RX_VALID = 1'b0;
  endtask

  task automatic send_load(input logic [7:0] n_byte);
    send_byte(8'h01);
    send_byte(n_byte);
    foreach (words[i]) begin
      send_byte(words[i][7:0]);
      send_byte(words[i][15:8]);
    end
    tick();
    tick();
  endtask

  task automatic verify_load(input int base);
    int cnt;
    cnt = words.size();
    check("wr_count", 32'(waddr_q.size() - base), 32'(cnt));
    for (int i = 0; i < cnt && base + i < waddr_q.size(); i++) begin
      check("wr_addr", 32'(waddr_q[base+i]), 32'(i % DEPTH));
      check("wr_data", 32'(wdata_q[base+i]), 32'(words[i] & 16'h1FFF));
    end
  endtask

  initial begin
    int base;
    logic [PC_LEN-1:0] pc0;
    logic [PC_LEN-1:0] bp;
    logic [7:0] eb;
    int n;

    RST = 1'b1; RX_VALID = 1'b0; RX_DATA = '0; PC = '0;
    repeat (3) tick();
    check("rst_rx_ready",  32'(RX_READY),   32'd0);
    check("rst_prom_we",   32'(PROM_WE),    32'd0);
    check("rst_waddr",     32'(PROM_WADDR), 32'd0);
    check("rst_wdata",     32'(PROM_WDATA), 32'd0);
    check("rst_core_rstn", 32'(CORE_RSTN),  32'd0);
    check("rst_core_ce",   32'(CORE_CE),    32'd0);
    check("rst_run_state", 32'(RUN_STATE),  32'd0);
    check("rst_err",       32'(ERR),        32'd0);
    RST = 1'b0;
    tick();
    check("rx_ready_after_rst", 32'(RX_READY), 32'd1);

    // Directed three-word load with per-word write timing.
    words = '{16'h1234, 16'h0ABC, 16'h1FFF};
    base = waddr_q.size();
    send_byte(8'h01);
    check("load_core_rstn", 32'(CORE_RSTN), 32'd0);
    send_byte(8'd3);
    for (int i = 0; i < 3; i++) begin
      send_byte(words[i][7:0]);
      send_byte(words[i][15:8]);
      check("we_pulse",    32'(PROM_WE),    32'd1);
      check("we_rx_ready", 32'(RX_READY),   32'd0);
      check("we_addr",     32'(PROM_WADDR), 32'(i));
      check("we_data",     32'(PROM_WDATA), 32'(words[i] & 16'h1FFF));
      tick();
      check("we_drop",       32'(PROM_WE),    32'd0);
      check("rx_ready_back", 32'(RX_READY),   32'd1);
      check("addr_inc",      32'(PROM_WADDR), 32'(i + 1));
    end
    tick();
    verify_load(base);
    check("load_rstn_held", 32'(CORE_RSTN), 32'd0);
    check("load_state",     32'(RUN_STATE), 32'd0);

    // RUN, HALT, two STEPs.
    send_byte(8'h02);
    check("run_state",  32'(RUN_STATE), 32'd1);
    check("run_rstn",   32'(CORE_RSTN), 32'd1);
    check("run_ce",     32'(CORE_CE),   32'd1);
    repeat (6) tick();
    check("run_pc", 32'(PC), 32'd6);
    send_byte(8'h03);
    check("halt_state", 32'(RUN_STATE), 32'd2);
    check("halt_ce",    32'(CORE_CE),   32'd0);
    pc0 = PC;
    tick();
    check("halt_pc_hold", 32'(PC), 32'(pc0));
    for (int k = 0; k < 2; k++) begin
      send_byte(8'h04);
      check("step_ce", 32'(CORE_CE), 32'd1);
      pc0 = PC;
      tick();
      check("step_once",  32'(CORE_CE),   32'd0);
      check("step_pc",    32'(PC),        32'(pc0 + 7'd1));
      check("step_state", 32'(RUN_STATE), 32'd2);
    end

    // Breakpoint at a random address, then resume past it.
    bp = 7'($urandom_range(3, 60));
    send_byte(8'h05);
    check("reset_state", 32'(RUN_STATE), 32'd0);
    check("reset_rstn",  32'(CORE_RSTN), 32'd0);
    send_byte(8'h06);
    send_byte({1'b0, bp});
    send_byte(8'h02);
    n = 0;
    while (PC != bp && n < 200) begin
      tick();
      n++;
    end
    check("bp_reached",    32'(PC),        32'(bp));
    check("bp_ce",         32'(CORE_CE),   32'd0);
    check("bp_state_same", 32'(RUN_STATE), 32'd1);
    tick();
    check("bp_halted",  32'(RUN_STATE), 32'd2);
    check("bp_pc_hold", 32'(PC),        32'(bp));
    send_byte(8'h02);
    check("resume_state", 32'(RUN_STATE), 32'd1);
    check("resume_ce",    32'(CORE_CE),   32'd1);
    check("resume_pc",    32'(PC),        32'(bp));
    tick();
    check("resume_left", 32'(PC), 32'(bp + 7'd1));
    repeat (3) tick();
    check("resume_no_rehalt", 32'(RUN_STATE), 32'd1);
    send_byte(8'h07);
    repeat (140) tick();
    check("brkoff_running", 32'(RUN_STATE), 32'd1);

    // Unknown command byte.
    eb = 8'($urandom_range(8, 255));
    send_byte(eb);
    check("err_set",      32'(ERR),       32'd1);
    check("err_no_state", 32'(RUN_STATE), 32'd1);
    send_byte(8'h03);
    check("err_then_halt", 32'(RUN_STATE), 32'd2);

    // 256-word load wraps the 128-entry address space twice.
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(16'($urandom));
    base = waddr_q.size();
    send_load(8'd0);
    verify_load(base);
    check("wrap_forced_reset", 32'(RUN_STATE), 32'd0);

    // Payload bytes equal to RUN must not be decoded as commands.
    words.delete();
    words.push_back(16'h0202);
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    base = waddr_q.size();
    send_load(8'(words.size()));
    verify_load(base);
    check("payload_not_cmd", 32'(RUN_STATE), 32'd0);

    // Reset in the middle of a load.
    send_byte(8'h01);
    send_byte(8'd5);
    send_byte(8'($urandom));
    base = waddr_q.size();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    repeat (4) tick();
    check("abort_no_we",   32'(waddr_q.size() - base), 32'd0);
    check("abort_waddr",   32'(PROM_WADDR), 32'd0);
    check("abort_err_clr", 32'(ERR),        32'd0);
    check("abort_rx_rdy",  32'(RX_READY),   32'd1);
    words.delete();
    words.push_back(16'($urandom));
    base = waddr_q.size();
    send_load(8'd1);
    verify_load(base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
